// File: rtl/gshare_predictor_pkg.sv
// gshare_predictor_pkg: shared BTB bit-select helpers, counter constants and branch-resolve bundle
package gshare_predictor_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] idx;
        logic        taken;
        logic [31:0] tar;
        logic        pred_taken;
        logic [31:0] pred_tar;
    } br_resolve_t;

    function automatic logic [31:0] btb_index(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int idx_w, input int tag_w);
        return (pc >> (idx_w + 2)) & ((32'd1 << tag_w) - 32'd1);
    endfunction

    function automatic int ctr_max(input int ctr_w);
        return (1 << ctr_w) - 1;
    endfunction

    function automatic int ctr_mid(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/gshare_predictor_sat_counter_table.sv
// sat_counter_table: ENTRIES x CTR_W saturating counters, combinational read, reset to midpoint
module sat_counter_table
    import gshare_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W = 2,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             inc,
    input  logic [IDX_W-1:0] widx,
    input  logic [IDX_W-1:0] ridx,
    output logic [CTR_W-1:0] rdata
);
    localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] MID = CTR_W'(ctr_mid(CTR_W));

    logic [CTR_W-1:0] ctr [ENTRIES];
    logic [CTR_W-1:0] cur;

    assign rdata = ctr[ridx];
    assign cur = ctr[widx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= MID;
        end else if (we) begin
            ctr[widx] <= inc ? ((cur == MAX) ? cur : cur + 1'b1)
                             : ((cur == '0) ? cur : cur - 1'b1);
        end
    end
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: tagged direct-mapped BTB plus bimodal/gshare PHT with committed global history
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W = 8,
    parameter int HIST_LEN = 6,
    parameter int CTR_W = 2,
    localparam int IDX_W = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [31:0]      if_pc,
    output logic             taken_o,
    output logic [31:0]      b_tar_o,
    output logic [IDX_W-1:0] pred_idx_o,
    input  logic             is_branch,
    input  logic [31:0]      ex_pc,
    input  logic [IDX_W-1:0] ex_idx_i,
    input  logic             taken_i,
    input  logic [31:0]      b_tar_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_tar_i,
    output logic [31:0]      br_cnt_o,
    output logic [31:0]      miss_cnt_o
);
    br_resolve_t      r;
    logic             clr;
    logic             upd;
    logic             miss;
    logic [IDX_W-1:0] if_bi;
    logic [IDX_W-1:0] ex_bi;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    logic [CTR_W-1:0] ctr_rd;
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0] tag [ENTRIES];
    logic [31:0]      tar [ENTRIES];

    assign r = '{pc: ex_pc, idx: 32'(ex_idx_i), taken: taken_i, tar: b_tar_i,
                 pred_taken: pred_taken_i, pred_tar: pred_tar_i};
    assign clr = rdy && rst;
    assign upd = rdy && !rst && is_branch;
    assign if_bi = IDX_W'(btb_index(if_pc, IDX_W));
    assign ex_bi = IDX_W'(btb_index(r.pc, IDX_W));
    assign if_tag = TAG_W'(btb_tag(if_pc, IDX_W, TAG_W));
    assign ex_tag = TAG_W'(btb_tag(r.pc, IDX_W, TAG_W));
    assign miss = (r.taken != r.pred_taken) || (r.taken && r.pred_taken && r.tar != r.pred_tar);

    always_comb begin
        taken_o = rdy && !rst && valid[if_bi] && tag[if_bi] == if_tag && ctr_rd[CTR_W-1];
        b_tar_o = taken_o ? tar[if_bi] : 32'd0;
    end

    generate
        if (HIST_LEN == 0) begin : g_bim
            assign pred_idx_o = if_bi;
        end else begin : g_gs
            logic [HIST_LEN-1:0] ghr;
            assign pred_idx_o = if_bi ^ IDX_W'(ghr);
            if (HIST_LEN == 1) begin : g_one
                always_ff @(posedge clk) begin
                    if (clr) ghr <= '0;
                    else if (upd) ghr <= r.taken;
                end
            end else begin : g_many
                always_ff @(posedge clk) begin
                    if (clr) ghr <= '0;
                    else if (upd) ghr <= {ghr[HIST_LEN-2:0], r.taken};
                end
            end
        end
    endgenerate

    sat_counter_table #(.ENTRIES(ENTRIES), .CTR_W(CTR_W)) u_pht (
        .clk(clk),
        .rst(clr),
        .we(upd),
        .inc(r.taken),
        .widx(IDX_W'(r.idx)),
        .ridx(pred_idx_o),
        .rdata(ctr_rd)
    );

    always_ff @(posedge clk) begin
        if (clr) valid <= '0;
        else if (upd) valid[ex_bi] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (upd) begin
            tag[ex_bi] <= ex_tag;
            tar[ex_bi] <= r.tar;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            br_cnt_o <= '0;
            miss_cnt_o <= '0;
        end else if (upd) begin
            br_cnt_o <= br_cnt_o + 32'd1;
            miss_cnt_o <= miss_cnt_o + {31'd0, miss};
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed vectors against a gshare instance and a bimodal instance
module tb_gshare_predictor;
    logic clk = 0;
    logic rst, rdy, is_branch, taken_i, pred_taken_i;
    logic [31:0] if_pc, ex_pc, b_tar_i, pred_tar_i;
    logic [5:0] ex_idx_i;
    logic tk_g, tk_b;
    logic [31:0] tar_g, tar_b, brc_g, brc_b, mc_g, mc_b;
    logic [5:0] idx_g, idx_b;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    gshare_predictor dut_g (
        .clk(clk), .rst(rst), .rdy(rdy), .if_pc(if_pc),
        .taken_o(tk_g), .b_tar_o(tar_g), .pred_idx_o(idx_g),
        .is_branch(is_branch), .ex_pc(ex_pc), .ex_idx_i(ex_idx_i), .taken_i(taken_i),
        .b_tar_i(b_tar_i), .pred_taken_i(pred_taken_i), .pred_tar_i(pred_tar_i),
        .br_cnt_o(brc_g), .miss_cnt_o(mc_g)
    );

    gshare_predictor #(.HIST_LEN(0)) dut_b (
        .clk(clk), .rst(rst), .rdy(rdy), .if_pc(if_pc),
        .taken_o(tk_b), .b_tar_o(tar_b), .pred_idx_o(idx_b),
        .is_branch(is_branch), .ex_pc(ex_pc), .ex_idx_i(ex_idx_i), .taken_i(taken_i),
        .b_tar_i(b_tar_i), .pred_taken_i(pred_taken_i), .pred_tar_i(pred_tar_i),
        .br_cnt_o(brc_b), .miss_cnt_o(mc_b)
    );

    typedef struct {
        logic br; logic [31:0] epc; logic [5:0] eidx; logic tk; logic [31:0] tar;
        logic ptk; logic [31:0] ptar; logic [31:0] lpc;
        logic etk; logic [31:0] etar; logic [5:0] eidxo; logic [31:0] ebr; logic [31:0] emiss;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input logic br, input logic [31:0] epc, input logic [5:0] eidx,
                       input logic tk, input logic [31:0] tar, input logic ptk, input logic [31:0] ptar);
        is_branch = br; ex_pc = epc; ex_idx_i = eidx; taken_i = tk;
        b_tar_i = tar; pred_taken_i = ptk; pred_tar_i = ptar;
    endtask

    task automatic do_reset();
        rst = 1; rdy = 1;
        res(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 0;
    endtask

    initial begin
        if_pc = 32'h1000;
        do_reset();
        tbl[0]  = '{0, 32'h1000, 0, 0, 32'h0,    0, 32'h0,    32'h1000, 0, 32'h0,    0, 0,  0};
        tbl[1]  = '{1, 32'h1000, 0, 1, 32'h2000, 0, 32'h0,    32'h1000, 1, 32'h2000, 0, 1,  1};
        tbl[2]  = '{1, 32'h1000, 0, 0, 32'h2000, 1, 32'h2000, 32'h1000, 1, 32'h2000, 0, 2,  2};
        tbl[3]  = '{1, 32'h1000, 0, 0, 32'h2000, 1, 32'h2000, 32'h1000, 0, 32'h0,    0, 3,  3};
        tbl[4]  = '{1, 32'h1000, 0, 1, 32'h2000, 1, 32'h2000, 32'h1000, 1, 32'h2000, 0, 4,  3};
        tbl[5]  = '{1, 32'h1000, 0, 1, 32'h2000, 1, 32'h2000, 32'h1000, 1, 32'h2000, 0, 5,  3};
        tbl[6]  = '{1, 32'h1000, 0, 1, 32'h2000, 1, 32'h2000, 32'h1000, 1, 32'h2000, 0, 6,  3};
        tbl[7]  = '{1, 32'h1000, 0, 1, 32'h2000, 1, 32'h2000, 32'h1000, 1, 32'h2000, 0, 7,  3};
        tbl[8]  = '{1, 32'h1000, 0, 1, 32'h2000, 1, 32'h2000, 32'h1000, 1, 32'h2000, 0, 8,  3};
        tbl[9]  = '{0, 32'h1000, 0, 0, 32'h0,    0, 32'h0,    32'h1100, 0, 32'h0,    0, 8,  3};
        tbl[10] = '{1, 32'h1000, 0, 1, 32'h2000, 1, 32'h3000, 32'h1000, 1, 32'h2000, 0, 9,  4};
        tbl[11] = '{1, 32'h1000, 0, 0, 32'h2000, 1, 32'h2000, 32'h1000, 1, 32'h2000, 0, 10, 5};
        tbl[12] = '{1, 32'h1000, 0, 0, 32'h2000, 1, 32'h2000, 32'h1000, 0, 32'h0,    0, 11, 6};
        tbl[13] = '{1, 32'h1004, 1, 0, 32'h5000, 0, 32'h0,    32'h1004, 0, 32'h0,    1, 12, 6};
        tbl[14] = '{1, 32'h1004, 1, 1, 32'h5000, 0, 32'h0,    32'h1004, 1, 32'h5000, 1, 13, 7};
        for (int i = 0; i < 15; i++) begin
            res(tbl[i].br, tbl[i].epc, tbl[i].eidx, tbl[i].tk, tbl[i].tar, tbl[i].ptk, tbl[i].ptar);
            tick();
            res(0, 0, 0, 0, 0, 0, 0);
            if_pc = tbl[i].lpc;
            #4;
            chk($sformatf("bim_taken[%0d]", i), tk_b, tbl[i].etk);
            chk($sformatf("bim_tar[%0d]", i), tar_b, tbl[i].etar);
            chk($sformatf("bim_idx[%0d]", i), idx_b, tbl[i].eidxo);
            chk($sformatf("bim_br[%0d]", i), brc_b, tbl[i].ebr);
            chk($sformatf("bim_miss[%0d]", i), mc_b, tbl[i].emiss);
        end

        // gshare: prime BTB[15] and BTB[10] with not-taken branches, then T,N,T
        do_reset();
        if_pc = 32'h1000;
        #4;
        chk("gs_cold_taken", tk_g, 0);
        chk("gs_cold_tar", tar_g, 0);
        chk("gs_cold_br", brc_g, 0);
        chk("gs_cold_miss", mc_g, 0);
        res(1, 32'h103C, 20, 0, 32'h7000, 0, 0); tick();
        res(1, 32'h1028, 21, 0, 32'h8000, 0, 0); tick();
        res(1, 32'h1000, 10, 1, 32'h2000, 0, 0); tick();
        res(1, 32'h1000, 10, 0, 32'h2000, 0, 0); tick();
        res(1, 32'h1000, 10, 1, 32'h2000, 0, 0); tick();
        res(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h1000; #1;
        chk("gs_idx_hist5", idx_g, 5);
        chk("gs_taken_hist5", tk_g, 1);
        chk("gs_tar_hist5", tar_g, 32'h2000);
        res(1, 32'h1000, 5, 0, 32'h2000, 1, 32'h2000); tick();
        res(0, 0, 0, 0, 0, 0, 0);
        if_pc = 32'h103C; #1;
        chk("gs_idx_pht5", idx_g, 5);
        chk("gs_taken_pht5", tk_g, 0);
        if_pc = 32'h1028; #1;
        chk("gs_idx_pht0", idx_g, 0);
        chk("gs_taken_pht0", tk_g, 1);
        chk("gs_tar_pht0", tar_g, 32'h8000);
        if_pc = 32'h1000; #1;
        chk("gs_idx_pht10", idx_g, 10);
        chk("gs_taken_pht10", tk_g, 1);
        chk("gs_br", brc_g, 6);
        chk("gs_miss", mc_g, 3);

        // reset with a simultaneous update
        rst = 1;
        res(1, 32'h1000, 0, 1, 32'h2000, 0, 0);
        #1;
        chk("rst_cycle_taken", tk_g, 0);
        chk("rst_cycle_tar", tar_g, 0);
        tick();
        rst = 0;
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rstp_taken_g", tk_g, 0);
        chk("rstp_taken_b", tk_b, 0);
        chk("rstp_br_g", brc_g, 0);
        chk("rstp_miss_g", mc_g, 0);
        chk("rstp_br_b", brc_b, 0);
        chk("rstp_miss_b", mc_b, 0);

        // rdy stall on the bimodal instance
        res(1, 32'h1000, 0, 1, 32'h2000, 0, 0); tick();
        rdy = 0;
        res(1, 32'h1004, 1, 1, 32'h9000, 0, 0);
        #1;
        chk("stall_taken", tk_b, 0);
        chk("stall_tar", tar_b, 0);
        tick();
        res(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        tick();
        rst = 0; rdy = 1;
        #1;
        chk("stall_kept_taken", tk_b, 1);
        chk("stall_kept_tar", tar_b, 32'h2000);
        chk("stall_br", brc_b, 1);
        chk("stall_miss", mc_b, 1);
        if_pc = 32'h1004; #1;
        chk("stall_no_train", tk_b, 0);

        // same-cycle update and lookup see the pre-update state
        if_pc = 32'h1000;
        res(1, 32'h1000, 0, 0, 32'h2000, 1, 32'h2000); tick();
        res(1, 32'h1000, 0, 0, 32'h2000, 1, 32'h2000);
        #1;
        chk("same_ctr_old", tk_b, 1);
        tick();
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("same_ctr_new", tk_b, 0);
        if_pc = 32'h1008;
        res(1, 32'h1008, 2, 1, 32'hA000, 0, 0);
        #1;
        chk("same_btb_old", tk_b, 0);
        tick();
        res(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("same_btb_new", tk_b, 1);
        chk("same_btb_tar", tar_b, 32'hA000);
        chk("final_br", brc_b, 4);
        chk("final_miss", mc_b, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised successor to the IF-stage bimodal predictor: a tagged, direct-mapped BTB plus a separate pattern history table (PHT) of saturating counters, indexed either by PC (bimodal) or by PC XOR global history (gshare). Prediction is combinational for the IF stage. Updates, global history and performance counters are sequential, driven by resolved branches from EX. The PHT index used at prediction travels down the pipeline with the instruction and returns at EX, so updates train the same entry that predicted.

## Interface
Parameters:
- `ENTRIES`, 64: BTB and PHT depth; power of two, ≥4. `IDX_W = log2(ENTRIES)`.
- `TAG_W`, 8: BTB tag width; tag = `pc[IDX_W+TAG_W+1 : IDX_W+2]`.
- `HIST_LEN`, 6: global history bits, 0..`IDX_W`; 0 selects bimodal mode.
- `CTR_W`, 2: PHT counter width, ≥1.

Ports (reset is synchronous and active-high):
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; when low, all state holds and outputs read as not-taken.
- `if_pc` in 32: fetch PC.
- `taken_o` out 1: predict taken.
- `b_tar_o` out 32: predicted target; 0 when not taken.
- `pred_idx_o` out `IDX_W`: PHT index used for this prediction.
- `is_branch` in 1: EX resolves a conditional branch this cycle.
- `ex_pc` in 32: PC of the resolved branch.
- `ex_idx_i` in `IDX_W`: `pred_idx_o` value carried with that branch.
- `taken_i` in 1: actual direction.
- `b_tar_i` in 32: actual target.
- `pred_taken_i` in 1: direction predicted for it at IF.
- `pred_tar_i` in 32: target predicted for it at IF.
- `br_cnt_o` out 32: resolved branches since reset.
- `miss_cnt_o` out 32: mispredicts since reset.

## Operation
- BTB index: `pc[IDX_W+1:2]`. Each entry holds valid, tag and target.
- PHT index:
  - bimodal mode: `pc[IDX_W+1:2]`.
  - gshare mode: `pc[IDX_W+1:2] ^ {{(IDX_W-HIST_LEN){0}}, ghr}`.
- Lookup (combinational):
  - `taken_o=1` when the BTB entry is valid, its tag matches `if_pc`, and the PHT counter MSB is 1. `b_tar_o` is then the stored target.
  - Otherwise `taken_o=0` and `b_tar_o=0`.
  - `pred_idx_o` is always driven, whether or not the prediction is taken.
- Update, on a rising edge with `rdy && !rst && is_branch`:
  - BTB[`ex_pc` index] is written with valid=1, tag of `ex_pc`, `b_tar_i`. Both taken and not-taken branches write the BTB.
  - PHT[`ex_idx_i`] counts +1 on taken, saturating at `2^CTR_W-1`; −1 on not-taken, saturating at 0.
  - `ghr <= {ghr[HIST_LEN-2:0], taken_i}`, so history is committed, not speculative. With `HIST_LEN=1`, `ghr<=taken_i`. With `HIST_LEN=0` there is no register.
  - `br_cnt_o` increments.
  - Mispredict = `taken_i != pred_taken_i`, or (`taken_i && pred_taken_i && b_tar_i != pred_tar_i`). On a mispredict, `miss_cnt_o` increments.
- Reset (`rdy && rst`):
  - all BTB valid bits clear;
  - all PHT counters set to `2^(CTR_W-1)` (weakly taken);
  - `ghr=0`, both counters 0.
  - BTB targets and tags are not cleared.
  - Reset has priority over a simultaneous update.
- Reset while `rdy=0` has no effect, matching the existing predictor. The bench always raises `rdy` during reset.

## Timing
- Prediction latency is 0 cycles: `taken_o`, `b_tar_o` and `pred_idx_o` follow `if_pc` and the current state in the same cycle.
- Update is visible to lookups from the cycle after the edge.
- Same-cycle update and lookup of the same entry: the lookup sees the pre-update value; there is no bypass.
- Output values:
  - `taken_o`/`b_tar_o` are 0 whenever `rst` or `!rdy`.
  - `pred_idx_o` is unconstrained in those cycles.
  - The counters read 0 in the cycle after reset.
- Performance counters wrap modulo 2^32.
- `ghr` changes only on update edges. A stall (`rdy=0`) freezes it along with all arrays.
- No handshake: EX asserts `is_branch` for exactly one cycle per resolved branch.

## Structure
- Shared package holds:
  - the BTB index/tag bit-select helpers, derived from `IDX_W`/`TAG_W`;
  - the counter-saturation constants;
  - the branch-resolve bundle (`ex_pc`, `ex_idx_i`, `taken_i`, `b_tar_i`, `pred_taken_i`, `pred_tar_i`) as a typedef, so EX and this block agree on it.
- One sub-module, `sat_counter_table`: an ENTRIES×CTR_W array with a combinational read port, a saturating inc/dec write port, and reset to the midpoint.
- BTB, GHR and the performance counters live in the top level.

## Test plan
All scenarios use the defaults (`ENTRIES=64, TAG_W=8, HIST_LEN=6, CTR_W=2`) unless stated.

- **Cold start.** After reset, `if_pc=0x1000` gives `taken_o=0`, `b_tar_o=0`; `br_cnt_o=0`, `miss_cnt_o=0`.
- **Bimodal train (`HIST_LEN=0`).** Resolve `ex_pc=0x1000` taken to 0x2000 once, with `pred_taken_i=0`. Next cycle, `if_pc=0x1000` gives `taken_o=1`, `b_tar_o=0x2000` (counter 2→3), and `miss_cnt_o=1`. Two not-taken resolves then give `taken_o=0`.
- **Saturation.** Five taken then one not-taken on the same index: the counter reads 3 and then 2, and the prediction stays taken.
- **Tag alias.** Train `0x1000` taken. `if_pc=0x1000+(64<<2)` has the same index and a different tag, and gives `taken_o=0`.
- **Gshare history.**
  - After the taken-resolve pattern T,N,T, `ghr=0b000101`.
  - `if_pc=0x1000` gives `pred_idx_o=0^5=5`.
  - An update with `ex_idx_i=5` changes PHT[5] only; PHT[0] is untouched.
- **Reset priority and rdy stall.**
  - `rst` and `is_branch` asserted together: no entry is trained, and the counters are 0.
  - With `rdy=0` and `is_branch=1`: no state change, and `taken_o=0` even for a trained PC.
  - Same-cycle update and lookup of the same entry: the lookup shows the old counter.
